// File: rtl/sd_clk_ctrl.sv
// rtl/sd_clk_ctrl.sv - SD card clock sequencer: selects the period count and drives a glitch-free sd_clk
//
// Ports:
//   clk, reset                      system clock, synchronous active-high reset
//   id_req, speed_req, tran_speed   host requests (ID rate, or rate from CSD TRAN_SPEED)
//   clk_stop                        hold sd_clk low at a period end (only with SD_CLK_GATE_EN)
//   gen_start, gen_tran_speed       handshake out to the divider count generator
//   gen_ok, gen_err, gen_count      generator result (gen_count[16] = valid)
//   sd_clk, sd_clk_rise/fall        card clock and its registered edge strobes
//   cur_count                       period count currently in use, 0 = stopped
//   busy, done, err                 request status
//
// Optional feature: define SD_CLK_GATE_EN to honour clk_stop.

module sd_clk_ctrl #(
    parameter int ID_COUNT     = 125,
    parameter int MIN_COUNT    = 2,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_req,
    input  logic        speed_req,
    input  logic [7:0]  tran_speed,
    input  logic        clk_stop,
    output logic        gen_start,
    output logic [7:0]  gen_tran_speed,
    input  logic        gen_ok,
    input  logic        gen_err,
    input  logic [16:0] gen_count,
    output logic        sd_clk,
    output logic        sd_clk_rise,
    output logic        sd_clk_fall,
    output logic [15:0] cur_count,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] ID_CNT   = 16'(ID_COUNT);
    localparam logic [15:0] MIN_CNT  = 16'(MIN_COUNT);
    localparam logic [15:0] TO_LAST  = 16'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        SWITCH
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pending, pending_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] phase_cnt;
    logic [15:0] hi_len, lo_len, new_hi;
    logic        done_nxt, err_nxt, latch_speed, commit;
    logic        gate, low_end;

`ifdef SD_CLK_GATE_EN
    assign gate = clk_stop;
`else
    logic unused_clk_stop;
    assign gate            = 1'b0;
    assign unused_clk_stop = clk_stop;
`endif

    // Odd counts put the extra cycle in the low phase.
    assign hi_len = cur_count >> 1;
    assign lo_len = cur_count - hi_len;
    assign new_hi = pending >> 1;

    // Last cycle of the low phase: the next edge would raise sd_clk, so this
    // is the only point a new count can take over without a short pulse.
    assign low_end = (cur_count != 16'd0) && !sd_clk && (phase_cnt == 16'd0);

    assign gen_start = (state == START);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        latch_speed = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                if (id_req) begin
                    pending_nxt = ID_CNT;
                    state_nxt   = SWITCH;
                end else if (speed_req) begin
                    // A zero time-value field has no defined rate.
                    if (tran_speed[6:3] == 4'd0) begin
                        err_nxt = 1'b1;
                    end else begin
                        latch_speed = 1'b1;
                        state_nxt   = LOAD;
                    end
                end
            end
            LOAD:  state_nxt = START;
            START: state_nxt = WAIT;
            WAIT: begin
                if (gen_ok && gen_count[16] && (gen_count[15:0] >= MIN_CNT)) begin
                    pending_nxt = gen_count[15:0];
                    state_nxt   = SWITCH;
                end else if (gen_ok || gen_err || (wait_cnt == TO_LAST)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SWITCH: begin
                if (!gate && ((cur_count == 16'd0) || low_end)) begin
                    commit    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pending        <= 16'd0;
            gen_tran_speed <= 8'd0;
            wait_cnt       <= 16'd0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            if (latch_speed) begin
                gen_tran_speed <= tran_speed;
            end
            if (state == START) begin
                wait_cnt <= 16'd0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    // phase_cnt holds the cycles left in the current phase after this one.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_count   <= 16'd0;
            phase_cnt   <= 16'd0;
            sd_clk      <= 1'b0;
            sd_clk_rise <= 1'b0;
            sd_clk_fall <= 1'b0;
        end else begin
            sd_clk_rise <= 1'b0;
            sd_clk_fall <= 1'b0;
            if (commit) begin
                cur_count   <= pending;
                phase_cnt   <= new_hi - 16'd1;
                sd_clk      <= 1'b1;
                sd_clk_rise <= 1'b1;
            end else if (cur_count != 16'd0) begin
                if (phase_cnt != 16'd0) begin
                    phase_cnt <= phase_cnt - 16'd1;
                end else if (sd_clk) begin
                    sd_clk      <= 1'b0;
                    sd_clk_fall <= 1'b1;
                    phase_cnt   <= lo_len - 16'd1;
                end else if (!gate) begin
                    sd_clk      <= 1'b1;
                    sd_clk_rise <= 1'b1;
                    phase_cnt   <= hi_len - 16'd1;
                end
            end
        end
    end

endmodule
